// File: rtl/picorv32_mem_arbiter.sv
// Two-requester arbiter in front of a single PicoRV32 native memory port.
// Registers the winning request, holds it until s_ready, then spends one DRAIN cycle.
module picorv32_mem_arbiter #(
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,

  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,

  output logic        s_valid,
  output logic        s_instr,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,

  output logic        busy,
  output logic        owner,
  output logic [1:0]  dbg_state
);

  // Handshake: a requester holds mN_valid and its fields stable until it sees
  // mN_ready for one cycle; downstream, s_* are held stable while s_valid=1
  // until s_ready=1, which completes the transfer in that same cycle.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        s_valid_q, s_valid_d;
  logic        s_instr_q, s_instr_d;
  logic [31:0] s_addr_q, s_addr_d;
  logic [31:0] s_wdata_q, s_wdata_d;
  logic [3:0]  s_wstrb_q, s_wstrb_d;
  logic        owner_q, owner_d;
  logic        pref_m1_q, pref_m1_d;
  logic        grant_m1;

  always_comb begin
    if (FIXED_PRIO != 0) begin
      grant_m1 = !m0_valid;
    end else begin
      grant_m1 = m1_valid && (!m0_valid || pref_m1_q);
    end
  end

  always_comb begin
    state_d   = state_q;
    s_valid_d = s_valid_q;
    s_instr_d = s_instr_q;
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
    s_wstrb_d = s_wstrb_q;
    owner_d   = owner_q;
    pref_m1_d = pref_m1_q;
    case (state_q)
      IDLE: begin
        if (m0_valid || m1_valid) begin
          state_d   = BUSY;
          s_valid_d = 1'b1;
          owner_d   = grant_m1;
          s_instr_d = grant_m1 ? m1_instr : m0_instr;
          s_addr_d  = grant_m1 ? m1_addr  : m0_addr;
          s_wdata_d = grant_m1 ? m1_wdata : m0_wdata;
          s_wstrb_d = grant_m1 ? m1_wstrb : m0_wstrb;
        end
      end
      BUSY: begin
        if (s_ready) begin
          state_d   = DRAIN;
          s_valid_d = 1'b0;
          pref_m1_d = !owner_q;
        end
      end
      // The served requester still shows valid here; ignore everything.
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      s_valid_q <= 1'b0;
      s_instr_q <= 1'b0;
      s_addr_q  <= 32'd0;
      s_wdata_q <= 32'd0;
      s_wstrb_q <= 4'd0;
      owner_q   <= 1'b0;
      pref_m1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_valid_q <= s_valid_d;
      s_instr_q <= s_instr_d;
      s_addr_q  <= s_addr_d;
      s_wdata_q <= s_wdata_d;
      s_wstrb_q <= s_wstrb_d;
      owner_q   <= owner_d;
      pref_m1_q <= pref_m1_d;
    end
  end

  // A completion coinciding with reset is dropped: the transfer is being abandoned.
  assign m0_ready  = s_ready && (state_q == BUSY) && !owner_q && !reset;
  assign m1_ready  = s_ready && (state_q == BUSY) &&  owner_q && !reset;
  assign m0_rdata  = s_rdata;
  assign m1_rdata  = s_rdata;

  assign s_valid   = s_valid_q;
  assign s_instr   = s_instr_q;
  assign s_addr    = s_addr_q;
  assign s_wdata   = s_wdata_q;
  assign s_wstrb   = s_wstrb_q;
  assign owner     = owner_q;
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_picorv32_mem_arbiter.sv
// Bench for picorv32_mem_arbiter: instance 0 is round-robin, instance 1 fixed priority.
// Cycle vectors, hand-written corner sequences, then random traffic against a model.
module tb_picorv32_mem_arbiter;

  logic        clk;
  logic        rst_i    [2];
  logic        m0_valid [2];
  logic        m0_instr [2];
  logic [31:0] m0_addr  [2];
  logic [31:0] m0_wdata [2];
  logic [3:0]  m0_wstrb [2];
  logic        m0_ready [2];
  logic [31:0] m0_rdata [2];
  logic        m1_valid [2];
  logic        m1_instr [2];
  logic [31:0] m1_addr  [2];
  logic [31:0] m1_wdata [2];
  logic [3:0]  m1_wstrb [2];
  logic        m1_ready [2];
  logic [31:0] m1_rdata [2];
  logic        s_valid  [2];
  logic        s_instr  [2];
  logic [31:0] s_addr   [2];
  logic [31:0] s_wdata  [2];
  logic [3:0]  s_wstrb  [2];
  logic        s_ready  [2];
  logic [31:0] s_rdata  [2];
  logic        busy     [2];
  logic        owner    [2];
  logic [1:0]  dbg_st   [2];

  int n_vec = 0;
  int n_err = 0;

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  picorv32_mem_arbiter #(.FIXED_PRIO(0)) dut_rr (
    .clk(clk), .reset(rst_i[0]),
    .m0_valid(m0_valid[0]), .m0_instr(m0_instr[0]), .m0_addr(m0_addr[0]),
    .m0_wdata(m0_wdata[0]), .m0_wstrb(m0_wstrb[0]), .m0_ready(m0_ready[0]), .m0_rdata(m0_rdata[0]),
    .m1_valid(m1_valid[0]), .m1_instr(m1_instr[0]), .m1_addr(m1_addr[0]),
    .m1_wdata(m1_wdata[0]), .m1_wstrb(m1_wstrb[0]), .m1_ready(m1_ready[0]), .m1_rdata(m1_rdata[0]),
    .s_valid(s_valid[0]), .s_instr(s_instr[0]), .s_addr(s_addr[0]), .s_wdata(s_wdata[0]),
    .s_wstrb(s_wstrb[0]), .s_ready(s_ready[0]), .s_rdata(s_rdata[0]),
    .busy(busy[0]), .owner(owner[0]), .dbg_state(dbg_st[0])
  );

  picorv32_mem_arbiter #(.FIXED_PRIO(1)) dut_fx (
    .clk(clk), .reset(rst_i[1]),
    .m0_valid(m0_valid[1]), .m0_instr(m0_instr[1]), .m0_addr(m0_addr[1]),
    .m0_wdata(m0_wdata[1]), .m0_wstrb(m0_wstrb[1]), .m0_ready(m0_ready[1]), .m0_rdata(m0_rdata[1]),
    .m1_valid(m1_valid[1]), .m1_instr(m1_instr[1]), .m1_addr(m1_addr[1]),
    .m1_wdata(m1_wdata[1]), .m1_wstrb(m1_wstrb[1]), .m1_ready(m1_ready[1]), .m1_rdata(m1_rdata[1]),
    .s_valid(s_valid[1]), .s_instr(s_instr[1]), .s_addr(s_addr[1]), .s_wdata(s_wdata[1]),
    .s_wstrb(s_wstrb[1]), .s_ready(s_ready[1]), .s_rdata(s_rdata[1]),
    .busy(busy[1]), .owner(owner[1]), .dbg_state(dbg_st[1])
  );

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit rst; bit v0; bit v1; bit sr;
    bit e_sv; bit e_r0; bit e_r1; bit e_busy; bit e_own;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit rst, input bit v0, input bit v1, input bit sr,
                     input bit sv, input bit r0, input bit r1, input bit bz, input bit ow);
    vec_t v;
    v.rst = rst; v.v0 = v0; v.v1 = v1; v.sr = sr;
    v.e_sv = sv; v.e_r0 = r0; v.e_r1 = r1; v.e_busy = bz; v.e_own = ow;
    tbl.push_back(v);
  endtask

  localparam logic [31:0] A0 = 32'h8000_0000;
  localparam logic [31:0] A1 = 32'h4000_0010;
  localparam logic [31:0] RD = 32'hDEAD_BEEF;

  // ---------------- random-phase reference model ----------------
  bit          txn_on [2];
  bit          drain_on [2];
  int          cur_own [2];
  logic        cur_instr [2];
  logic [31:0] cur_addr [2];
  logic [31:0] cur_wdata [2];
  logic [3:0]  cur_wstrb [2];
  int          last_srv [2];
  int          wait_n [2];
  bit          pend [2][2];
  bit          cool [2][2];
  logic        q_instr [2][2];
  logic [31:0] q_addr [2][2];
  logic [31:0] q_wdata [2][2];
  logic [3:0]  q_wstrb [2][2];
  bit          do_rst [2];

  task automatic drive_req(input int i);
    m0_valid[i] = pend[i][0] | cool[i][0];
    m0_instr[i] = q_instr[i][0];
    m0_addr[i]  = q_addr[i][0];
    m0_wdata[i] = q_wdata[i][0];
    m0_wstrb[i] = q_wstrb[i][0];
    m1_valid[i] = pend[i][1] | cool[i][1];
    m1_instr[i] = q_instr[i][1];
    m1_addr[i]  = q_addr[i][1];
    m1_wdata[i] = q_wdata[i][1];
    m1_wstrb[i] = q_wstrb[i][1];
  endtask

  task automatic check_model(input int i);
    bit e0, e1;
    e0 = s_ready[i] && txn_on[i] && (cur_own[i] == 0);
    e1 = s_ready[i] && txn_on[i] && (cur_own[i] == 1);
    chk("rnd_s_valid", s_valid[i], txn_on[i]);
    chk("rnd_busy", busy[i], txn_on[i] | drain_on[i]);
    chk("rnd_owner", owner[i], cur_own[i]);
    chk("rnd_m0_ready", m0_ready[i], e0);
    chk("rnd_m1_ready", m1_ready[i], e1);
    chk("rnd_m0_rdata", m0_rdata[i], s_rdata[i]);
    chk("rnd_m1_rdata", m1_rdata[i], s_rdata[i]);
    if (txn_on[i]) begin
      chk("rnd_s_addr", s_addr[i], cur_addr[i]);
      chk("rnd_s_wdata", s_wdata[i], cur_wdata[i]);
      chk("rnd_s_wstrb", s_wstrb[i], cur_wstrb[i]);
      chk("rnd_s_instr", s_instr[i], cur_instr[i]);
    end
  endtask

  task automatic step_model(input int i);
    int w;
    bit done;
    int done_n;
    done = 0;
    done_n = 0;
    if (rst_i[i]) begin
      txn_on[i] = 0; drain_on[i] = 0; cur_own[i] = 0; last_srv[i] = 1;
      cur_instr[i] = 0; cur_addr[i] = 0; cur_wdata[i] = 0; cur_wstrb[i] = 0;
    end else if (txn_on[i]) begin
      if (s_ready[i]) begin
        txn_on[i] = 0; drain_on[i] = 1; last_srv[i] = cur_own[i];
        done = 1; done_n = cur_own[i];
      end else begin
        wait_n[i]--;
      end
    end else if (drain_on[i]) begin
      drain_on[i] = 0;
    end else if (m0_valid[i] || m1_valid[i]) begin
      if (i == 1)                          w = m0_valid[i] ? 0 : 1;
      else if (m0_valid[i] && m1_valid[i]) w = (last_srv[i] == 0) ? 1 : 0;
      else                                 w = m0_valid[i] ? 0 : 1;
      cur_own[i]   = w;
      cur_instr[i] = q_instr[i][w];
      cur_addr[i]  = q_addr[i][w];
      cur_wdata[i] = q_wdata[i][w];
      cur_wstrb[i] = q_wstrb[i][w];
      txn_on[i]    = 1;
      wait_n[i]    = $urandom_range(0, 3);
    end
    for (int n = 0; n < 2; n++) cool[i][n] = 0;
    if (done) begin
      pend[i][done_n] = 0;
      cool[i][done_n] = 1;
    end
    for (int n = 0; n < 2; n++) begin
      if (!pend[i][n] && !cool[i][n] && ($urandom_range(0, 2) == 0)) begin
        pend[i][n]    = 1;
        q_instr[i][n] = 1'($urandom_range(0, 1));
        q_addr[i][n]  = $urandom;
        q_wdata[i][n] = $urandom;
        q_wstrb[i][n] = 4'($urandom_range(0, 15));
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int r1cnt;

    for (int i = 0; i < 2; i++) begin
      rst_i[i] = 1; m0_valid[i] = 0; m0_instr[i] = 0; m0_addr[i] = 0; m0_wdata[i] = 0;
      m0_wstrb[i] = 0; m1_valid[i] = 0; m1_instr[i] = 0; m1_addr[i] = 0; m1_wdata[i] = 0;
      m1_wstrb[i] = 0; s_ready[i] = 0; s_rdata[i] = 0;
    end
    cyc();
    cyc();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_s_valid", s_valid[i], 0);
      chk("rst_s_instr", s_instr[i], 0);
      chk("rst_s_addr", s_addr[i], 0);
      chk("rst_s_wdata", s_wdata[i], 0);
      chk("rst_s_wstrb", s_wstrb[i], 0);
      chk("rst_owner", owner[i], 0);
      chk("rst_busy", busy[i], 0);
      chk("rst_state", dbg_st[i], 0);
    end
    cyc();
    rst_i[0] = 0;
    rst_i[1] = 0;

    // Single read, spurious s_ready, reset, then round-robin contention.
    //  rst v0 v1 sr | sv r0 r1 busy own
    add(0, 1, 0, 0,  0, 0, 0, 0, 0);
    add(0, 1, 0, 0,  1, 0, 0, 1, 0);
    add(0, 1, 0, 0,  1, 0, 0, 1, 0);
    add(0, 1, 0, 1,  1, 1, 0, 1, 0);
    add(0, 1, 0, 0,  0, 0, 0, 1, 0);
    add(0, 0, 0, 0,  0, 0, 0, 0, 0);
    add(0, 0, 0, 1,  0, 0, 0, 0, 0);
    add(1, 0, 0, 0,  0, 0, 0, 0, 0);
    add(0, 1, 1, 0,  0, 0, 0, 0, 0);
    add(0, 1, 1, 1,  1, 1, 0, 1, 0);
    add(0, 1, 1, 1,  0, 0, 0, 1, 0);
    add(0, 1, 1, 0,  0, 0, 0, 0, 0);
    add(0, 1, 1, 0,  1, 0, 0, 1, 1);
    add(0, 1, 1, 1,  1, 0, 1, 1, 1);
    add(0, 1, 1, 0,  0, 0, 0, 1, 1);
    add(0, 1, 1, 0,  0, 0, 0, 0, 1);
    add(0, 1, 1, 1,  1, 1, 0, 1, 0);
    add(0, 1, 1, 0,  0, 0, 0, 1, 0);
    add(0, 1, 1, 0,  0, 0, 0, 0, 0);
    add(0, 1, 1, 1,  1, 0, 1, 1, 1);
    add(0, 0, 0, 0,  0, 0, 0, 1, 1);
    add(0, 0, 0, 0,  0, 0, 0, 0, 1);

    m0_instr[0] = 1; m0_addr[0] = A0; m0_wdata[0] = 0; m0_wstrb[0] = 0;
    m1_instr[0] = 0; m1_addr[0] = A1; m1_wdata[0] = 32'h1234_5678; m1_wstrb[0] = 4'hF;
    s_rdata[0] = RD;
    foreach (tbl[k]) begin
      rst_i[0] = tbl[k].rst; m0_valid[0] = tbl[k].v0; m1_valid[0] = tbl[k].v1;
      s_ready[0] = tbl[k].sr;
      @(negedge clk);
      chk("tbl_s_valid", s_valid[0], tbl[k].e_sv);
      chk("tbl_m0_ready", m0_ready[0], tbl[k].e_r0);
      chk("tbl_m1_ready", m1_ready[0], tbl[k].e_r1);
      chk("tbl_busy", busy[0], tbl[k].e_busy);
      chk("tbl_owner", owner[0], tbl[k].e_own);
      if (tbl[k].e_sv) begin
        chk("tbl_s_addr", s_addr[0], tbl[k].e_own ? A1 : A0);
        chk("tbl_s_instr", s_instr[0], tbl[k].e_own ? 0 : 1);
      end
      if (tbl[k].e_r0) chk("tbl_m0_rdata", m0_rdata[0], RD);
      if (tbl[k].e_r1) chk("tbl_m1_rdata", m1_rdata[0], RD);
      cyc();
    end
    rst_i[0] = 0;

    // Write hold: m1 write, 5 wait cycles, m0 churning, m1 drops valid early.
    m0_valid[0] = 0; m1_valid[0] = 1; m1_instr[0] = 0; m1_addr[0] = A1;
    m1_wdata[0] = 32'hF0FF_0FAA; m1_wstrb[0] = 4'b1100; s_ready[0] = 0;
    @(negedge clk);
    chk("wh_idle_busy", busy[0], 0);
    cyc();
    r1cnt = 0;
    for (int k = 0; k < 6; k++) begin
      m0_valid[0] = 1'($urandom_range(0, 1));
      m0_instr[0] = 1'($urandom_range(0, 1));
      m0_addr[0]  = $urandom;
      m0_wdata[0] = $urandom;
      m0_wstrb[0] = 4'($urandom_range(0, 15));
      if (k == 2) m1_valid[0] = 0;
      s_ready[0] = (k == 5);
      @(negedge clk);
      chk("wh_s_valid", s_valid[0], 1);
      chk("wh_s_addr", s_addr[0], A1);
      chk("wh_s_wdata", s_wdata[0], 32'hF0FF_0FAA);
      chk("wh_s_wstrb", s_wstrb[0], 4'b1100);
      chk("wh_s_instr", s_instr[0], 0);
      chk("wh_owner", owner[0], 1);
      chk("wh_m0_ready", m0_ready[0], 0);
      if (m1_ready[0]) r1cnt++;
      cyc();
    end
    m0_valid[0] = 0; s_ready[0] = 0;
    @(negedge clk);
    chk("wh_drain_s_valid", s_valid[0], 0);
    chk("wh_drain_busy", busy[0], 1);
    if (m1_ready[0]) r1cnt++;
    cyc();
    chk("wh_m1_ready_count", r1cnt, 1);
    @(negedge clk);
    chk("wh_idle_after", busy[0], 0);
    cyc();

    // Reset in the middle of a transfer, then a late s_ready.
    m0_valid[0] = 1; m0_instr[0] = 0; m0_addr[0] = 32'h8000_0100;
    m0_wdata[0] = 32'h1122_3344; m0_wstrb[0] = 4'hF; m1_valid[0] = 0; s_ready[0] = 0;
    @(negedge clk);
    cyc();
    rst_i[0] = 1;
    @(negedge clk);
    chk("mr_pre_s_valid", s_valid[0], 1);
    chk("mr_pre_m0_ready", m0_ready[0], 0);
    cyc();
    rst_i[0] = 0; m0_valid[0] = 0; s_ready[0] = 1;
    @(negedge clk);
    chk("mr_s_valid", s_valid[0], 0);
    chk("mr_busy", busy[0], 0);
    chk("mr_owner", owner[0], 0);
    chk("mr_s_addr", s_addr[0], 0);
    chk("mr_s_wdata", s_wdata[0], 0);
    chk("mr_s_wstrb", s_wstrb[0], 0);
    chk("mr_s_instr", s_instr[0], 0);
    chk("mr_late_m0_ready", m0_ready[0], 0);
    chk("mr_late_m1_ready", m1_ready[0], 0);
    cyc();
    s_ready[0] = 0; m1_valid[0] = 1; m1_addr[0] = 32'h4000_0020;
    @(negedge clk);
    cyc();
    s_ready[0] = 1;
    @(negedge clk);
    chk("mr_next_s_valid", s_valid[0], 1);
    chk("mr_next_owner", owner[0], 1);
    chk("mr_next_s_addr", s_addr[0], 32'h4000_0020);
    chk("mr_next_m1_ready", m1_ready[0], 1);
    chk("mr_next_m0_ready", m0_ready[0], 0);
    cyc();
    m1_valid[0] = 0; s_ready[0] = 0;
    @(negedge clk);
    chk("mr_next_drain", busy[0], 1);
    cyc();

    // Fixed priority: m1 starved while m0 valid, granted as soon as m0 stops.
    m0_addr[1] = 32'h0000_0100; m1_addr[1] = 32'h0000_0200;
    for (int t = 0; t < 4; t++) begin
      m0_valid[1] = (t < 3); m1_valid[1] = 1; s_ready[1] = 0;
      @(negedge clk);
      chk("fx_idle_busy", busy[1], 0);
      cyc();
      s_ready[1] = 1;
      @(negedge clk);
      chk("fx_s_valid", s_valid[1], 1);
      chk("fx_owner", owner[1], (t < 3) ? 0 : 1);
      chk("fx_s_addr", s_addr[1], (t < 3) ? 32'h100 : 32'h200);
      chk("fx_m0_ready", m0_ready[1], (t < 3) ? 1 : 0);
      chk("fx_m1_ready", m1_ready[1], (t < 3) ? 0 : 1);
      cyc();
      s_ready[1] = 0;
      @(negedge clk);
      chk("fx_drain_busy", busy[1], 1);
      chk("fx_drain_s_valid", s_valid[1], 0);
      cyc();
    end
    m0_valid[1] = 0; m1_valid[1] = 0;

    // Random traffic on both instances against the model.
    for (int i = 0; i < 2; i++) begin
      rst_i[i] = 1; s_ready[i] = 0;
      txn_on[i] = 0; drain_on[i] = 0; cur_own[i] = 0; last_srv[i] = 1; wait_n[i] = 0;
      cur_instr[i] = 0; cur_addr[i] = 0; cur_wdata[i] = 0; cur_wstrb[i] = 0;
      for (int n = 0; n < 2; n++) begin
        pend[i][n] = 0; cool[i][n] = 0;
        q_instr[i][n] = 0; q_addr[i][n] = 0; q_wdata[i][n] = 0; q_wstrb[i][n] = 0;
      end
      drive_req(i);
    end
    cyc();
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < 2; i++) begin
        do_rst[i] = ($urandom_range(0, 99) == 0);
        rst_i[i] = do_rst[i];
        drive_req(i);
        if (do_rst[i])      s_ready[i] = 0;
        else if (txn_on[i]) s_ready[i] = (wait_n[i] == 0);
        else                s_ready[i] = ($urandom_range(0, 5) == 0);
        s_rdata[i] = $urandom;
      end
      @(negedge clk);
      for (int i = 0; i < 2; i++) check_model(i);
      for (int i = 0; i < 2; i++) step_model(i);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
